// File: rtl/mm_job_arbiter.sv
// mm_job_arbiter
// Shares one signed matrix-multiply engine (operands up to 4x4) between two
// requesters. Grants round-robin, streams the owner's A then B operand in
// row-major order with end-of-row / end-of-matrix markers, samples the
// engine's legality verdict, routes results back to the owner and closes
// every job with a one-cycle done pulse (plus err on failure).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_i[1:0]               per-requester job request (level)
//   dims0_i, dims1_i         {r1,c1,r2,c2}, 3 bits each, legal 1..4
//   src_data0_i, src_data1_i current operand element of each requester
//   gnt_o[1:0]               registered one-hot owner
//   src_rd_o[1:0]            owner's element consumed this cycle
//   mm_in_data_o             element to engine
//   mm_col_end_o             last element of a row
//   mm_row_end_o             last element of a matrix
//   mm_busy_i, mm_valid_i, mm_is_legal_i, mm_change_row_i, mm_out_data_i
//                            engine status and result
//   res_valid_o[1:0]         result valid, owner's bit only
//   res_data_o               result element
//   res_row_end_o            last element of a result row
//   done_o[1:0], err_o[1:0]  one-cycle job completion / failure pulses
//
// state    | meaning
// IDLE     | no owner; arbitrate among pending requests
// GRANT    | latch and validate the owner's dims
// FEED_A   | stream operand A, one element per cycle
// FEED_B   | stream operand B, one element per cycle
// WAIT_CHK | wait for engine busy, sample legality, bounded by TMO
// DRAIN    | forward engine results to the owner
// DONE     | pulse done/err, release grant, advance pointer

module mm_job_arbiter #(
   parameter int DW  = 8,
   parameter int OW  = 20,
   parameter int TMO = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_i,
   input  logic [11:0]   dims0_i,
   input  logic [11:0]   dims1_i,
   input  logic [DW-1:0] src_data0_i,
   input  logic [DW-1:0] src_data1_i,
   output logic [1:0]    gnt_o,
   output logic [1:0]    src_rd_o,
   output logic [DW-1:0] mm_in_data_o,
   output logic          mm_col_end_o,
   output logic          mm_row_end_o,
   input  logic          mm_busy_i,
   input  logic          mm_valid_i,
   input  logic          mm_is_legal_i,
   input  logic          mm_change_row_i,
   input  logic [OW-1:0] mm_out_data_i,
   output logic [1:0]    res_valid_o,
   output logic [OW-1:0] res_data_o,
   output logic          res_row_end_o,
   output logic [1:0]    done_o,
   output logic [1:0]    err_o
);

   localparam int TW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_FEED_A,
      S_FEED_B,
      S_WAIT_CHK,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic          ptr_q;
   logic          own_q;
   logic [1:0]    gnt_q;
   logic [2:0]    r1_q, c1_q, r2_q, c2_q;
   logic [2:0]    row_q, col_q;
   logic [4:0]    out_cnt_q;
   logic [TW-1:0] tmo_q;
   logic [1:0]    res_valid_q;
   logic [OW-1:0] res_data_q;
   logic          res_row_end_q;
   logic [1:0]    done_q;
   logic [1:0]    err_q;

   logic [11:0] own_dims;
   logic        dims_bad;
   logic        pick;
   logic        feeding;
   logic [2:0]  cur_r, cur_c;
   logic        col_last, row_last;
   logic [5:0]  res_total;
   logic [4:0]  out_cnt_nxt;

   function automatic logic field_bad(input logic [2:0] f);
      return (f == 3'd0) || (f > 3'd4);
   endfunction

   always_comb begin
      own_dims    = own_q ? dims1_i : dims0_i;
      dims_bad    = field_bad(own_dims[11:9]) || field_bad(own_dims[8:6]) ||
                    field_bad(own_dims[5:3])  || field_bad(own_dims[2:0]);
      // the pointer names the requester with priority; the other wins only if alone
      pick        = req_i[ptr_q] ? ptr_q : ~ptr_q;
      feeding     = (state_q == S_FEED_A) || (state_q == S_FEED_B);
      cur_r       = (state_q == S_FEED_B) ? r2_q : r1_q;
      cur_c       = (state_q == S_FEED_B) ? c2_q : c1_q;
      col_last    = (col_q == cur_c - 3'd1);
      row_last    = (row_q == cur_r - 3'd1);
      res_total   = 6'(r1_q) * 6'(c2_q);
      out_cnt_nxt = out_cnt_q + {4'd0, mm_valid_i};
   end

   // feed path is combinational so the element and its markers track src_data
   assign src_rd_o      = feeding ? gnt_q : 2'b00;
   assign mm_in_data_o  = feeding ? (own_q ? src_data1_i : src_data0_i) : '0;
   assign mm_col_end_o  = feeding & col_last;
   assign mm_row_end_o  = feeding & col_last & row_last;

   assign gnt_o         = gnt_q;
   assign res_valid_o   = res_valid_q;
   assign res_data_o    = res_data_q;
   assign res_row_end_o = res_row_end_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= 1'b0;
         own_q         <= 1'b0;
         gnt_q         <= 2'b00;
         r1_q          <= 3'd0;
         c1_q          <= 3'd0;
         r2_q          <= 3'd0;
         c2_q          <= 3'd0;
         row_q         <= 3'd0;
         col_q         <= 3'd0;
         out_cnt_q     <= 5'd0;
         tmo_q         <= '0;
         res_valid_q   <= 2'b00;
         res_data_q    <= '0;
         res_row_end_q <= 1'b0;
         done_q        <= 2'b00;
         err_q         <= 2'b00;
      end else begin
         res_valid_q   <= 2'b00;
         res_row_end_q <= 1'b0;
         done_q        <= 2'b00;
         err_q         <= 2'b00;
         case (state_q)
            S_IDLE: begin
               if (|req_i) begin
                  own_q   <= pick;
                  gnt_q   <= {pick, ~pick};
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               r1_q  <= own_dims[11:9];
               c1_q  <= own_dims[8:6];
               r2_q  <= own_dims[5:3];
               c2_q  <= own_dims[2:0];
               row_q <= 3'd0;
               col_q <= 3'd0;
               if (dims_bad) begin
                  done_q  <= gnt_q;
                  err_q   <= gnt_q;
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_FEED_A;
               end
            end
            S_FEED_A, S_FEED_B: begin
               if (col_last) begin
                  col_q <= 3'd0;
                  if (row_last) begin
                     row_q <= 3'd0;
                     if (state_q == S_FEED_A) begin
                        state_q <= S_FEED_B;
                     end else begin
                        tmo_q   <= TW'(TMO);
                        state_q <= S_WAIT_CHK;
                     end
                  end else begin
                     row_q <= row_q + 3'd1;
                  end
               end else begin
                  col_q <= col_q + 3'd1;
               end
            end
            S_WAIT_CHK: begin
               if (mm_busy_i) begin
                  if (mm_is_legal_i) begin
                     out_cnt_q <= 5'd0;
                     state_q   <= S_DRAIN;
                  end else begin
                     done_q  <= gnt_q;
                     err_q   <= gnt_q;
                     state_q <= S_DONE;
                  end
               end else if (tmo_q <= TW'(1)) begin
                  done_q  <= gnt_q;
                  err_q   <= gnt_q;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_q - TW'(1);
               end
            end
            S_DRAIN: begin
               if (mm_valid_i) begin
                  res_data_q    <= mm_out_data_i;
                  res_valid_q   <= gnt_q;
                  res_row_end_q <= mm_change_row_i;
                  out_cnt_q     <= out_cnt_nxt;
               end
               // a result arriving in the exit cycle still counts toward the total
               if (!mm_busy_i) begin
                  done_q  <= gnt_q;
                  err_q   <= ({1'b0, out_cnt_nxt} == res_total) ? 2'b00 : gnt_q;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               gnt_q     <= 2'b00;
               ptr_q     <= ~own_q;
               row_q     <= 3'd0;
               col_q     <= 3'd0;
               out_cnt_q <= 5'd0;
               tmo_q     <= '0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Testbench for mm_job_arbiter: directed jobs plus randomized rounds, with a
// behavioural engine stub and a reference model (round-robin owner, expected
// feed stream, matrix products, done/err and latency rules).

module tb_mm_job_arbiter;

   localparam int DW  = 8;
   localparam int OW  = 20;
   localparam int TMO = 8;

   logic          clk, rst;
   logic [1:0]    req;
   logic [11:0]   dims0, dims1;
   logic [DW-1:0] src_data0, src_data1;
   logic [1:0]    gnt, src_rd;
   logic [DW-1:0] mm_in_data;
   logic          mm_col_end, mm_row_end;
   logic          mm_busy, mm_valid, mm_is_legal, mm_change_row;
   logic [OW-1:0] mm_out_data;
   logic [1:0]    res_valid;
   logic [OW-1:0] res_data;
   logic          res_row_end;
   logic [1:0]    done, err;

   mm_job_arbiter #(.DW(DW), .OW(OW), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .req_i(req), .dims0_i(dims0), .dims1_i(dims1),
      .src_data0_i(src_data0), .src_data1_i(src_data1),
      .gnt_o(gnt), .src_rd_o(src_rd), .mm_in_data_o(mm_in_data),
      .mm_col_end_o(mm_col_end), .mm_row_end_o(mm_row_end),
      .mm_busy_i(mm_busy), .mm_valid_i(mm_valid), .mm_is_legal_i(mm_is_legal),
      .mm_change_row_i(mm_change_row), .mm_out_data_i(mm_out_data),
      .res_valid_o(res_valid), .res_data_o(res_data), .res_row_end_o(res_row_end),
      .done_o(done), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {int d; bit ce; bit re;} feed_t;
   typedef struct {int d; bit re;} res_t;

   int n_chk = 0, n_err = 0;
   int cyc = 0;

   // job descriptions per requester
   int src_mem [2][32];
   int src_ptr [2];
   int j_r1 [2], j_c1 [2], j_r2 [2], j_c2 [2], j_mode [2];
   int m_ptr;

   // expectations for the current job
   feed_t exp_feed [$];
   res_t  exp_res  [$];
   int    exp_owner, exp_feed_n, exp_res_n;
   bit    exp_err;
   int    ra [16], rb [16];

   // observations for the current job
   int feed_n, res_n, gnt_cyc, first_feed, last_feed, done_cyc;
   bit done_seen;
   logic [1:0] gnt_prev;

   // engine stub: mode 0 normal, 1 forced illegal, 2 never busy, 3 one result short
   int cap [$];
   int eng_res [$];
   int ea [16], eb [16];
   int eng_mode, eng_r1, eng_c1, eng_r2, eng_c2;
   int eng_phase, eng_wait, eng_idx, eng_n, eng_ends;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int mm_elem(input int a [16], input int b [16],
                                  input int c1, input int c2, input int idx);
      int s, i, j;
      s = 0;
      i = idx / c2;
      j = idx % c2;
      for (int k = 0; k < c1; k++) s += a[i*c1 + k] * b[k*c2 + j];
      return s;
   endfunction

   function automatic bit fbad(input int f);
      return (f < 1) || (f > 4);
   endfunction

   task automatic drive_src();
      src_data0 = (src_ptr[0] < 32) ? 8'(src_mem[0][src_ptr[0]]) : 8'h00;
      src_data1 = (src_ptr[1] < 32) ? 8'(src_mem[1][src_ptr[1]]) : 8'h00;
   endtask

   task automatic eng_emit();
      if (eng_idx < eng_n) begin
         mm_valid      = 1'b1;
         mm_out_data   = OW'(eng_res[eng_idx]);
         mm_change_row = ((eng_idx % eng_c2) == eng_c2 - 1);
         eng_idx++;
      end else begin
         mm_valid      = 1'b0;
         mm_busy       = 1'b0;
         mm_is_legal   = 1'b0;
         mm_change_row = 1'b0;
         eng_phase     = 0;
      end
   endtask

   task automatic eng_clear();
      mm_busy = 1'b0; mm_valid = 1'b0; mm_is_legal = 1'b0; mm_change_row = 1'b0;
      mm_out_data = '0;
      eng_phase = 0; eng_ends = 0;
      cap.delete();
      eng_res.delete();
   endtask

   // monitor, source driver and engine stub, all at the falling edge
   initial begin
      feed_t f;
      res_t  rr;
      gnt_prev = 2'b00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (gnt != 2'b00 && gnt_prev == 2'b00) begin
               chk("gnt_owner", int'(gnt), 1 << exp_owner);
               gnt_cyc = cyc;
            end else if (gnt != 2'b00) begin
               chk("gnt_hold", int'(gnt), int'(gnt_prev));
            end
            gnt_prev = gnt;

            chk("res_lat", int'(|res_valid), int'(mm_valid));
            if (|res_valid) begin
               chk("res_owner", int'(res_valid), 1 << exp_owner);
               res_n++;
               if (exp_res.size() > 0) begin
                  rr = exp_res.pop_front();
                  chk("res_data", int'($signed(res_data)), rr.d);
                  chk("res_row_end", int'(res_row_end), int'(rr.re));
               end
            end

            if (done != 2'b00) begin
               chk("done", int'(done), 1 << exp_owner);
               chk("err", int'(err), exp_err ? (1 << exp_owner) : 0);
               done_seen = 1'b1;
               done_cyc  = cyc;
            end else begin
               chk("err_alone", int'(err), 0);
            end

            case (eng_phase)
               1: begin
                  eng_wait--;
                  if (eng_wait == 0) begin
                     if (eng_mode == 2) begin
                        eng_phase = 0;
                     end else begin
                        for (int i = 0; i < 16; i++) begin ea[i] = 0; eb[i] = 0; end
                        for (int i = 0; i < eng_r1*eng_c1; i++) ea[i] = cap[i];
                        for (int i = 0; i < eng_r2*eng_c2; i++) eb[i] = cap[eng_r1*eng_c1 + i];
                        eng_res.delete();
                        mm_is_legal = (eng_mode != 1) && (eng_c1 == eng_r2);
                        if (mm_is_legal)
                           for (int i = 0; i < eng_r1*eng_c2; i++)
                              eng_res.push_back(mm_elem(ea, eb, eng_c1, eng_c2, i));
                        eng_n   = eng_r1*eng_c2 - ((eng_mode == 3) ? 1 : 0);
                        eng_idx = 0;
                        mm_busy = 1'b1;
                        eng_phase = 2;
                     end
                  end
               end
               2: begin
                  if (!mm_is_legal) begin
                     mm_busy = 1'b0;
                     eng_phase = 0;
                  end else begin
                     eng_phase = 3;
                     eng_emit();
                  end
               end
               3: eng_emit();
               default: ;
            endcase

            if (src_rd != 2'b00) begin
               chk("src_rd", int'(src_rd), 1 << exp_owner);
               if (exp_feed.size() > 0) begin
                  f = exp_feed.pop_front();
                  chk("feed_data", int'($signed(mm_in_data)), f.d);
                  chk("feed_ends", int'({mm_col_end, mm_row_end}), int'({f.ce, f.re}));
               end
               if (feed_n == 0) first_feed = cyc;
               last_feed = cyc;
               feed_n++;
               cap.push_back(int'($signed(mm_in_data)));
               if (mm_row_end) begin
                  eng_ends++;
                  if (eng_ends == 2) begin
                     eng_phase = 1;
                     eng_wait  = 2;
                  end
               end
               for (int r = 0; r < 2; r++) if (src_rd[r]) src_ptr[r]++;
               drive_src();
            end else begin
               chk("feed_idle", int'({mm_in_data, mm_col_end, mm_row_end}), 0);
            end
         end
      end
   end

   task automatic setup(input int r, input int r1, input int c1, input int r2,
                        input int c2, input int mode);
      j_r1[r] = r1; j_c1[r] = c1; j_r2[r] = r2; j_c2[r] = c2; j_mode[r] = mode;
      for (int i = 0; i < 32; i++) src_mem[r][i] = int'($urandom_range(0, 255)) - 128;
      if (r == 0) dims0 = {3'(r1), 3'(c1), 3'(r2), 3'(c2)};
      else        dims1 = {3'(r1), 3'(c1), 3'(r2), 3'(c2)};
   endtask

   task automatic prep(input int o);
      feed_t f;
      res_t  rr;
      bit    bad;
      int    na, nb, n;
      bad = fbad(j_r1[o]) || fbad(j_c1[o]) || fbad(j_r2[o]) || fbad(j_c2[o]);
      exp_owner = o;
      exp_err   = bad || (j_mode[o] != 0) || (j_c1[o] != j_r2[o]);
      exp_feed.delete();
      exp_res.delete();
      na = j_r1[o] * j_c1[o];
      nb = j_r2[o] * j_c2[o];
      if (!bad) begin
         for (int i = 0; i < na; i++) begin
            f.d = src_mem[o][i]; f.ce = ((i % j_c1[o]) == j_c1[o] - 1); f.re = (i == na - 1);
            exp_feed.push_back(f);
         end
         for (int i = 0; i < nb; i++) begin
            f.d = src_mem[o][na + i]; f.ce = ((i % j_c2[o]) == j_c2[o] - 1); f.re = (i == nb - 1);
            exp_feed.push_back(f);
         end
         if ((j_mode[o] == 0 || j_mode[o] == 3) && j_c1[o] == j_r2[o]) begin
            for (int i = 0; i < 16; i++) begin ra[i] = 0; rb[i] = 0; end
            for (int i = 0; i < na; i++) ra[i] = src_mem[o][i];
            for (int i = 0; i < nb; i++) rb[i] = src_mem[o][na + i];
            n = j_r1[o] * j_c2[o] - ((j_mode[o] == 3) ? 1 : 0);
            for (int i = 0; i < n; i++) begin
               rr.d  = mm_elem(ra, rb, j_c1[o], j_c2[o], i);
               rr.re = ((i % j_c2[o]) == j_c2[o] - 1);
               exp_res.push_back(rr);
            end
         end
      end
      exp_feed_n = bad ? 0 : na + nb;
      exp_res_n  = exp_res.size();
      eng_clear();
      eng_mode = j_mode[o];
      eng_r1 = j_r1[o]; eng_c1 = j_c1[o]; eng_r2 = j_r2[o]; eng_c2 = j_c2[o];
      feed_n = 0; res_n = 0; done_seen = 1'b0;
      gnt_cyc = 0; first_feed = 0; last_feed = 0; done_cyc = 0;
      src_ptr[o] = 0;
      drive_src();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"},  int'(gnt), 0);
      chk({tag, "_feed"}, int'({src_rd, mm_in_data, mm_col_end, mm_row_end}), 0);
      chk({tag, "_res"},  int'({res_valid, res_row_end}), 0);
      chk({tag, "_rdat"}, int'(res_data), 0);
      chk({tag, "_done"}, int'({done, err}), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk_zero("rst_zero");
      eng_clear();
      exp_feed.delete();
      exp_res.delete();
      req = 2'b00;
      m_ptr = 0;
      gnt_prev = 2'b00;
      done_seen = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic run_round(input bit p0, input bit p1);
      bit pend0, pend1, first;
      int o;
      pend0 = p0; pend1 = p1; first = 1'b1;
      while (pend0 || pend1) begin
         o = (pend0 && pend1) ? m_ptr : (pend0 ? 0 : 1);
         prep(o);
         if (first) begin
            req = {p1, p0};
            first = 1'b0;
         end
         for (int t = 0; t < 500 && !done_seen; t++) begin
            @(posedge clk);
            #2;
         end
         if (!done_seen) begin
            chk("done_timeout", int'(done_seen), 1);
            do_reset();
            return;
         end
         chk("feed_cnt", feed_n, exp_feed_n);
         chk("res_cnt", res_n, exp_res_n);
         if (exp_feed_n == 0) begin
            chk("bad_dims_lat", done_cyc - gnt_cyc, 1);
         end else begin
            chk("feed_lat", first_feed - gnt_cyc, 1);
            chk("feed_len", last_feed - first_feed + 1, exp_feed_n);
            if (eng_mode == 2) chk("tmo_len", done_cyc - last_feed, TMO + 1);
         end
         if (o == 0) begin pend0 = 1'b0; req[0] = 1'b0; end
         else        begin pend1 = 1'b0; req[1] = 1'b0; end
         m_ptr = 1 - o;
      end
   endtask

   initial begin
      int pat, m, r1, c1, r2, c2;
      rst = 1'b1; req = 2'b00; dims0 = '0; dims1 = '0;
      src_data0 = '0; src_data1 = '0;
      src_ptr[0] = 0; src_ptr[1] = 0;
      m_ptr = 0; exp_owner = 0; exp_err = 1'b0;
      eng_clear();
      repeat (3) @(posedge clk);
      #2;
      chk_zero("init");
      rst = 1'b0;

      // both requesters from reset, 1x1 jobs: owner 0 then 1
      setup(0, 1, 1, 1, 1, 0); src_mem[0][0] = -1; src_mem[0][1] = -128;
      setup(1, 1, 1, 1, 1, 0); src_mem[1][0] = 3;  src_mem[1][1] = 5;
      run_round(1'b1, 1'b1);

      // 2x2 * 2x2 on requester 0
      setup(0, 2, 2, 2, 2, 0);
      for (int i = 0; i < 8; i++) src_mem[0][i] = i + 1;
      run_round(1'b1, 1'b0);

      // inner dimensions differ: engine flags illegal
      setup(1, 2, 3, 2, 2, 0);
      run_round(1'b0, 1'b1);

      // zero dimension: no engine activity
      setup(0, 0, 2, 2, 2, 0);
      run_round(1'b1, 1'b0);

      // engine never busy: timeout
      setup(1, 2, 2, 2, 2, 2);
      run_round(1'b0, 1'b1);

      // engine delivers one result too few
      setup(0, 3, 2, 2, 4, 3);
      run_round(1'b1, 1'b0);

      // reset during the drain of a 4x4 job, then a clean rerun
      setup(0, 4, 4, 4, 4, 0);
      prep(0);
      req = 2'b01;
      for (int t = 0; t < 300 && res_n < 2; t++) begin
         @(posedge clk);
         #2;
      end
      chk("rst_wait_res", res_n, 2);
      do_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("no_done_after_rst", int'(done_seen), 0);
      setup(0, 4, 4, 4, 4, 0);
      run_round(1'b1, 1'b0);

      // randomized rounds
      for (int k = 0; k < 40; k++) begin
         for (int r = 0; r < 2; r++) begin
            r1 = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 4));
            c1 = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(1, 4));
            r2 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : c1;
            c2 = int'($urandom_range(1, 4));
            m  = int'($urandom_range(0, 9));
            m  = (m < 7) ? 0 : m - 6;
            setup(r, r1, c1, r2, c2, m);
         end
         pat = int'($urandom_range(1, 3));
         run_round(pat[0], pat[1]);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
